// File: rtl/ll_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ll_sync_pkg
// Purpose  : Shared types and helpers for the Logic Link receive word-sync
//            checker: FSM state encoding, default marker pattern and the
//            marker bit-position function.
// Revision : 1.0 - initial release
// ============================================================================
package ll_sync_pkg;

    // Receive sync FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_ONLINE = 2'd3
    } sync_state_t;

    // Persistent marker pattern inserted by the transmit side (bit k = marker k)
    localparam logic [3:0] C_EXP_MRK_DEFAULT = 4'b1000;

    // Marker k occupies the top bit of its PHY_WIDTH/MARKER_WIDTH lane
    function automatic int mrk_bit_idx(input int phy_width, input int mrk_width, input int k);
        return (k + 1) * (phy_width / mrk_width) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ll_rx_word_check.sv
`default_nettype none
// ============================================================================
// Module   : ll_rx_word_check
// Purpose  : Combinational good-word compare of one received PHY word:
//            strobe userbit set and all checked markers at their expected
//            value. Gen1 checks marker 0 only (expected 1).
// Revision : 1.0 - initial release
// ============================================================================
module ll_rx_word_check
    import ll_sync_pkg::*;
#(
    parameter int                      PHY_WIDTH    = 320,
    parameter int                      MARKER_WIDTH = 4,
    parameter int                      STB_LOC      = 1,
    parameter logic [MARKER_WIDTH-1:0] EXP_MRK      = C_EXP_MRK_DEFAULT
) (
    input  logic [PHY_WIDTH-1:0]    i_rx_phy,
    input  logic                    i_gen2_mode,
    output logic                    o_good,
    output logic [MARKER_WIDTH-1:0] o_mismatch
);

    logic [MARKER_WIDTH-1:0] w_mrk;
    logic [MARKER_WIDTH-1:0] w_exp;
    logic [MARKER_WIDTH-1:0] w_mask;
    logic                    w_unused_phy;

    // Gather the marker userbits from the top of each lane
    for (genvar k = 0; k < MARKER_WIDTH; k++) begin : g_mrk
        assign w_mrk[k] = i_rx_phy[mrk_bit_idx(PHY_WIDTH, MARKER_WIDTH, k)];
    end

    // Select which markers are checked and what they must read
    always_comb begin
        w_mask = '1;
        w_exp  = EXP_MRK;
        if (!i_gen2_mode) begin
            w_mask    = '0;
            w_mask[0] = 1'b1;
            w_exp     = '0;
            w_exp[0]  = 1'b1;
        end
    end

    assign o_mismatch = (w_mrk ^ w_exp) & w_mask;
    assign o_good     = i_rx_phy[STB_LOC] & ~(|o_mismatch);

    // Payload bits are not inspected here
    assign w_unused_phy = ^i_rx_phy;

endmodule
`default_nettype wire

// File: rtl/ll_rx_sync_check.sv
`default_nettype none
// ============================================================================
// Module   : ll_rx_sync_check
// Purpose  : Receive-side word-sync checker. Declares word lock after
//            LOCK_CNT consecutive good words, raises rx_online_delay a
//            programmable number of cycles later and drops both after
//            UNLOCK_CNT consecutive bad words, counting lock losses.
//            Optional macro LL_RX_SYNC_STATUS_EN enables the registered
//            debug status word; otherwise it reads 32'h0.
// Revision : 1.0 - initial release
// ============================================================================
module ll_rx_sync_check
    import ll_sync_pkg::*;
#(
    parameter int                      PHY_WIDTH    = 320,
    parameter int                      MARKER_WIDTH = 4,
    parameter int                      STB_LOC      = 1,
    parameter logic [MARKER_WIDTH-1:0] EXP_MRK      = C_EXP_MRK_DEFAULT,
    parameter int                      LOCK_CNT     = 8,
    parameter int                      UNLOCK_CNT   = 4
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 rx_online,
    input  logic [PHY_WIDTH-1:0] rx_phy,
    input  logic                 m_gen2_mode,
    input  logic [7:0]           delay_x_value,
    output logic                 rx_word_lock,
    output logic                 rx_online_delay,
    output logic [15:0]          rx_sync_err_cnt,
    output logic [31:0]          rx_sync_debug_status
);

    localparam logic [7:0] C_LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] C_UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    sync_state_t             r_state;
    sync_state_t             w_state_nxt;
    logic                    w_good;
    logic [MARKER_WIDTH-1:0] w_mismatch;
    logic                    r_good;
    logic [7:0]              r_good_cnt;
    logic [7:0]              w_good_cnt_nxt;
    logic [7:0]              w_good_cnt_inc;
    logic [7:0]              r_bad_cnt;
    logic [7:0]              w_bad_cnt_nxt;
    logic [7:0]              r_dly_cnt;
    logic [7:0]              w_dly_cnt_nxt;
    logic [15:0]             r_err_cnt;
    logic [15:0]             w_err_cnt_nxt;

    ll_rx_word_check #(
        .PHY_WIDTH    (PHY_WIDTH),
        .MARKER_WIDTH (MARKER_WIDTH),
        .STB_LOC      (STB_LOC),
        .EXP_MRK      (EXP_MRK)
    ) u_word_check (
        .i_rx_phy    (rx_phy),
        .i_gen2_mode (m_gen2_mode),
        .o_good      (w_good),
        .o_mismatch  (w_mismatch)
    );

    // Register the compare result; the FSM acts on it one cycle later
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) r_good <= 1'b0;
        else           r_good <= w_good;
    end

    // FSM state register
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    assign w_good_cnt_inc = (r_good_cnt == 8'hFF) ? r_good_cnt : r_good_cnt + 8'd1;

    // Next state and counter updates; rx_online low overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_dly_cnt_nxt  = r_dly_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        if (!rx_online) begin
            w_state_nxt    = ST_IDLE;
            w_good_cnt_nxt = 8'd0;
            w_bad_cnt_nxt  = 8'd0;
            w_dly_cnt_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_HUNT;
                end
                ST_HUNT: begin
                    if (r_good) begin
                        w_good_cnt_nxt = w_good_cnt_inc;
                        if (r_good_cnt >= C_LOCK_LAST) begin
                            w_state_nxt   = ST_DELAY;
                            w_dly_cnt_nxt = delay_x_value;
                        end
                    end else begin
                        w_good_cnt_nxt = 8'd0;
                    end
                end
                ST_DELAY, ST_ONLINE: begin
                    if (r_state == ST_DELAY) begin
                        if (r_dly_cnt == 8'd0) w_state_nxt   = ST_ONLINE;
                        else                   w_dly_cnt_nxt = r_dly_cnt - 8'd1;
                    end
                    if (r_good) begin
                        w_good_cnt_nxt = w_good_cnt_inc;
                        w_bad_cnt_nxt  = 8'd0;
                    end else if (r_bad_cnt >= C_UNLOCK_LAST) begin
                        // Persistent mismatch: back to hunting, count the loss
                        w_state_nxt    = ST_HUNT;
                        w_good_cnt_nxt = 8'd0;
                        w_bad_cnt_nxt  = 8'd0;
                        w_dly_cnt_nxt  = 8'd0;
                        w_err_cnt_nxt  = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
                    end else begin
                        w_good_cnt_nxt = 8'd0;
                        w_bad_cnt_nxt  = r_bad_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Counter registers
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_good_cnt <= 8'd0;
            r_bad_cnt  <= 8'd0;
            r_dly_cnt  <= 8'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            r_good_cnt <= w_good_cnt_nxt;
            r_bad_cnt  <= w_bad_cnt_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign rx_word_lock    = (r_state == ST_DELAY) || (r_state == ST_ONLINE);
    assign rx_online_delay = (r_state == ST_ONLINE);
    assign rx_sync_err_cnt = r_err_cnt;

`ifdef LL_RX_SYNC_STATUS_EN
    logic [7:0] r_last_mis;

    // Hold the most recent non-zero marker mismatch seen while online
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n)                       r_last_mis <= 8'd0;
        else if (rx_online && |w_mismatch)   r_last_mis <= 8'(w_mismatch);
    end

    assign rx_sync_debug_status = {r_state, 6'b0, r_good_cnt, r_bad_cnt, r_last_mis};
`else
    logic w_unused_mismatch;

    assign w_unused_mismatch    = ^w_mismatch;
    assign rx_sync_debug_status = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ll_rx_sync_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_ll_rx_sync_check
// Purpose  : Self-checking bench for ll_rx_sync_check. A driver issues PHY
//            words and pushes the reference model's expected outputs into a
//            queue; a monitor pops and compares once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ll_rx_sync_check;

    localparam int PW     = 320;
    localparam int LOCK   = 8;
    localparam int UNLOCK = 4;

    logic          clk_wr = 1'b0;
    logic          rst_wr_n;
    logic          rx_online;
    logic [PW-1:0] rx_phy;
    logic          m_gen2_mode;
    logic [7:0]    delay_x_value;
    logic          rx_word_lock;
    logic          rx_online_delay;
    logic [15:0]   rx_sync_err_cnt;
    logic [31:0]   rx_sync_debug_status;

    ll_rx_sync_check #(
        .PHY_WIDTH  (PW),
        .LOCK_CNT   (LOCK),
        .UNLOCK_CNT (UNLOCK)
    ) dut (
        .clk_wr               (clk_wr),
        .rst_wr_n             (rst_wr_n),
        .rx_online            (rx_online),
        .rx_phy               (rx_phy),
        .m_gen2_mode          (m_gen2_mode),
        .delay_x_value        (delay_x_value),
        .rx_word_lock         (rx_word_lock),
        .rx_online_delay      (rx_online_delay),
        .rx_sync_err_cnt      (rx_sync_err_cnt),
        .rx_sync_debug_status (rx_sync_debug_status)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct packed {
        logic        lock;
        logic        onl;
        logic [15:0] err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: run-length view of the received word stream
    bit m_active, m_locked, m_pg;
    int m_good_run, m_bad_run, m_age, m_dly, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_pg = 0;
        m_good_run = 0; m_bad_run = 0; m_age = 0; m_dly = 0; m_err = 0;
    endtask

    // One clock edge: the word judged is the one captured at the previous edge
    task automatic model_edge(input bit online, input bit word_good, input int dly_in);
        if (!online) begin
            m_active = 0; m_locked = 0; m_good_run = 0; m_bad_run = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (!m_locked) begin
            if (m_pg) begin
                m_good_run++;
                if (m_good_run >= LOCK) begin
                    m_locked = 1; m_age = 0; m_dly = dly_in; m_bad_run = 0;
                end
            end else begin
                m_good_run = 0;
            end
        end else begin
            if (m_age < 1000) m_age++;
            if (m_pg) m_bad_run = 0;
            else begin
                m_bad_run++;
                if (m_bad_run >= UNLOCK) begin
                    m_locked = 0; m_good_run = 0; m_bad_run = 0;
                    if (m_err < 65535) m_err++;
                end
            end
        end
        m_pg = word_good;
    endtask

    function automatic logic [PW-1:0] make_word(input bit good, input bit gen2);
        logic [PW-1:0] w;
        int            sel;
        for (int i = 0; i < PW / 32; i++) w[i*32 +: 32] = $urandom;
        w[1] = 1'b1;
        if (gen2) begin
            w[79] = 1'b0; w[159] = 1'b0; w[239] = 1'b0; w[319] = 1'b1;
        end else begin
            w[79] = 1'b1;
        end
        if (!good) begin
            sel = gen2 ? $urandom_range(0, 4) : $urandom_range(0, 1);
            case (sel)
                0: w[1]   = 1'b0;
                1: w[79]  = ~w[79];
                2: w[159] = ~w[159];
                3: w[239] = ~w[239];
                default: w[319] = ~w[319];
            endcase
        end
        return w;
    endfunction

    task automatic step(input bit online, input bit good, input bit gen2, input logic [7:0] dly);
        exp_t e;
        @(negedge clk_wr);
        rx_online     = online;
        m_gen2_mode   = gen2;
        delay_x_value = dly;
        rx_phy        = make_word(good, gen2);
        model_edge(online, good, int'(dly));
        e.lock = m_locked;
        e.onl  = m_locked && (m_age > m_dly);
        e.err  = 16'(m_err);
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit online, input bit good, input bit gen2, input logic [7:0] dly);
        for (int i = 0; i < n; i++) step(online, good, gen2, dly);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lock"},   32'(rx_word_lock), 32'd0);
        check({tag, "_online"}, 32'(rx_online_delay), 32'd0);
        check({tag, "_errcnt"}, 32'(rx_sync_err_cnt), 32'd0);
        check({tag, "_status"}, rx_sync_debug_status, 32'd0);
    endtask

    // Monitor: compare the DUT against the queued expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_wr);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("word_lock",   32'(rx_word_lock),    32'(e.lock));
                check("online_dly",  32'(rx_online_delay), 32'(e.onl));
                check("sync_errcnt", 32'(rx_sync_err_cnt), 32'(e.err));
`ifndef LL_RX_SYNC_STATUS_EN
                check("debug_status", rx_sync_debug_status, 32'd0);
`endif
            end
        end
    end

    // Driver
    initial begin
        int pbad;
        bit g2;
        rst_wr_n = 1'b0; rx_online = 1'b0; m_gen2_mode = 1'b1;
        delay_x_value = 8'd0; rx_phy = '0;
        model_reset();
        repeat (3) @(posedge clk_wr);
        #1 check_all_zero("reset");
        @(negedge clk_wr) rst_wr_n = 1'b1;

        // Gen2 lock with delay 5, then settle in ONLINE
        run(2, 0, 1, 1, 8'd5);
        run(20, 1, 1, 1, 8'd5);

        // Hunt restart: 7 good, 1 bad, 8 good
        run(2, 0, 1, 1, 8'd3);
        run(7, 1, 1, 1, 8'd3);
        run(1, 1, 0, 1, 8'd3);
        run(14, 1, 1, 1, 8'd3);

        // Unlock: 3 bad, 1 good, 4 bad
        run(3, 1, 0, 1, 8'd3);
        run(1, 1, 1, 1, 8'd3);
        run(4, 1, 0, 1, 8'd3);
        run(3, 1, 1, 1, 8'd3);

        // Gen1 lock with zero delay, then unlock on marker 0
        run(2, 0, 1, 0, 8'd0);
        run(12, 1, 1, 0, 8'd0);
        run(4, 1, 0, 0, 8'd0);
        run(3, 1, 1, 0, 8'd0);

        // Unlock threshold coincides with rx_online falling
        run(2, 0, 1, 1, 8'd2);
        run(14, 1, 1, 1, 8'd2);
        run(4, 1, 0, 1, 8'd2);
        run(1, 0, 0, 1, 8'd2);
        run(2, 0, 1, 1, 8'd2);

        // Asynchronous reset while in DELAY
        run(13, 1, 1, 1, 8'd40);
        @(negedge clk_wr);
        rst_wr_n = 1'b0; rx_online = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk_wr);
        @(negedge clk_wr) rst_wr_n = 1'b1;

        // Error counter saturation
        run(2, 0, 1, 1, 8'd0);
        @(negedge clk_wr) force dut.r_err_cnt = 16'hFFFE;
        @(negedge clk_wr) release dut.r_err_cnt;
        m_err = 65534;
        for (int k = 0; k < 2; k++) begin
            run(11, 1, 1, 1, 8'd0);
            run(4, 1, 0, 1, 8'd0);
        end
        run(3, 1, 1, 1, 8'd0);

        // Randomized traffic in segments of varying error density
        for (int s = 0; s < 20; s++) begin
            case ($urandom_range(0, 2))
                0:       pbad = 3;
                1:       pbad = 30;
                default: pbad = 70;
            endcase
            g2 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 80; i++)
                step($urandom_range(0, 99) != 0, $urandom_range(0, 99) >= pbad, g2,
                     8'($urandom_range(0, 12)));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_wr);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
